// File: rtl/divider_check_pkg.sv
// Shared types and constants for the divider result-checking blocks.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
//
// Contents:
//   state_t    - FSM encoding of the reconstruct checker (IDLE, MUL, DONE)
//   DEF_DW     - default operand width (divisor, quotient, remainder)
//   DEF_NW     - derived dividend width, always 2*DW
//   cnt_width  - width of the iteration counter for a given DW
package divider_check_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    localparam int DEF_DW = 8;
    localparam int DEF_NW = 2 * DEF_DW;

    // The counter must hold DW-1. A one-bit floor keeps a DW=1 build legal,
    // because $clog2(1) would otherwise give a zero-width counter.
    function automatic int cnt_width(input int dw);
        return (dw > 1) ? $clog2(dw) : 1;
    endfunction

    localparam int DEF_CNT_W = cnt_width(DEF_DW);

endpackage : divider_check_pkg

// File: rtl/divider_abs_diff.sv
// Unsigned absolute difference |a - b| with ordering flags.
// Latency: purely combinational, zero cycles.
// Backpressure: none; the outputs follow the inputs.
//
// Ports:
//   a, b      - W-bit unsigned operands
//   diff      - |a - b|
//   a_gt_b    - a > b
//   a_eq_b    - a == b
module divider_abs_diff #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         a_gt_b,
    output logic         a_eq_b
);

    always_comb begin
        a_gt_b = (a > b);
        a_eq_b = (a == b);
        // Always subtract the smaller value from the larger one, so the
        // unsigned result can never wrap.
        if (a_gt_b) begin
            diff = a - b;
        end else begin
            diff = b - a;
        end
    end

endmodule : divider_abs_diff

// File: rtl/divider_reconstruct_seq.sv
// Rebuilds the dividend as q*d + r with a shift-add multiplier and reports the error against n.
// Latency: fixed DW cycles from the accept edge to out_valid; one result per transaction.
// Backpressure: in_ready is high only in IDLE; the result is held in DONE until out_ready.
//
// Ports:
//   clk, rst_n             - clock, asynchronous active-low reset
//   in_valid / in_ready    - operand handshake (n, d, q, r sampled on the accept edge)
//   out_valid / out_ready  - result handshake
//   n_rec                  - reconstructed dividend q*d + r
//   err_abs, err_over      - |n - n_rec| and n_rec > n
//   match                  - n_rec == n
//   r_ge_d, d_zero         - remainder not reduced, divisor zero (from the accepted operands)
module divider_reconstruct_seq
    import divider_check_pkg::*;
#(
    parameter  int DW = DEF_DW,
    localparam int NW = 2 * DW
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [NW-1:0] n,
    input  logic [DW-1:0] d,
    input  logic [DW-1:0] q,
    input  logic [DW-1:0] r,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [NW-1:0] n_rec,
    output logic [NW-1:0] err_abs,
    output logic          err_over,
    output logic          match,
    output logic          r_ge_d,
    output logic          d_zero
);

    localparam int            CW       = cnt_width(DW);
    localparam logic [CW-1:0] CNT_LAST = CW'(DW - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t        state;
    state_t        state_nxt;

    logic [NW-1:0] n_q;     // dividend captured at accept
    logic [NW-1:0] acc;     // running product, preloaded with r
    logic [NW-1:0] mcand;   // multiplicand d, shifted left each iteration
    logic [DW-1:0] mq;      // multiplier q, shifted right each iteration
    logic [CW-1:0] cnt;     // iteration index 0 .. DW-1

    logic          accept;
    logic          mul_step;
    logic          mul_last;
    logic [NW-1:0] acc_sum;

    logic [NW-1:0] diff_w;
    logic          gt_w;
    logic          eq_w;

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        mul_step  = 1'b0;
        mul_last  = 1'b0;

        case (state)
            ST_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    state_nxt = ST_MUL;
                end
            end

            ST_MUL: begin
                // No early exit on a zero multiplier: the latency stays
                // fixed, so throughput measurements in the harness do not
                // depend on the operands.
                mul_step = 1'b1;
                if (cnt == CNT_LAST) begin
                    mul_last  = 1'b1;
                    state_nxt = ST_DONE;
                end
            end

            ST_DONE: begin
                // in_ready stays low here, so a new operand set can never be
                // accepted on the same edge that releases the result.
                out_valid = 1'b1;
                if (out_ready) begin
                    state_nxt = ST_IDLE;
                end
            end

            default: begin
                state_nxt = ST_IDLE;
            end
        endcase
    end

    assign accept = in_ready & in_valid;

    // ------------------------------------------------------------------
    // Shift-add step. acc_sum is the accumulator value after the current
    // iteration. On the last iteration it is the final q*d + r, which feeds
    // the comparator directly. The result registers are therefore loaded
    // on the same edge that enters DONE.
    // ------------------------------------------------------------------
    assign acc_sum = mq[0] ? (acc + mcand) : acc;

    divider_abs_diff #(
        .W (NW)
    ) u_abs_diff (
        .a      (acc_sum),
        .b      (n_q),
        .diff   (diff_w),
        .a_gt_b (gt_w),
        .a_eq_b (eq_w)
    );

    // ------------------------------------------------------------------
    // Operand capture and multiplier iteration
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= '0;
            acc    <= '0;
            mcand  <= '0;
            mq     <= '0;
            cnt    <= '0;
            r_ge_d <= 1'b0;
            d_zero <= 1'b0;
        end else if (accept) begin
            // The worst case (2^DW-1)^2 + (2^DW-1) = 2^NW - 2^DW fits in NW
            // bits, so the accumulator never needs a carry-out.
            n_q    <= n;
            acc    <= {{(NW-DW){1'b0}}, r};
            mcand  <= {{(NW-DW){1'b0}}, d};
            mq     <= q;
            cnt    <= '0;
            r_ge_d <= (r >= d);
            d_zero <= (d == '0);
        end else if (mul_step) begin
            acc   <= acc_sum;
            mcand <= mcand << 1;
            mq    <= mq >> 1;
            cnt   <= cnt + CNT_ONE;
        end
    end

    // ------------------------------------------------------------------
    // Result registers. They are written only on the edge that enters
    // DONE. They hold through DONE and keep their values after release,
    // until the next transaction finishes or reset clears them.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_rec    <= '0;
            err_abs  <= '0;
            err_over <= 1'b0;
            match    <= 1'b0;
        end else if (mul_last) begin
            n_rec    <= acc_sum;
            err_abs  <= diff_w;
            err_over <= gt_w;
            match    <= eq_w;
        end
    end

endmodule : divider_reconstruct_seq

// File: tb/tb_divider_reconstruct_seq.sv
// Directed self-checking bench for divider_reconstruct_seq.
// Latency: checks the fixed 8-cycle accept-to-valid delay and the 10-cycle period.
// Backpressure: holds out_ready low in DONE and pulses in_valid while busy.
module tb_divider_reconstruct_seq;

    localparam int DW = 8;
    localparam int NW = 16;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [NW-1:0] n;
    logic [DW-1:0] d;
    logic [DW-1:0] q;
    logic [DW-1:0] r;
    logic          out_valid;
    logic          out_ready;
    logic [NW-1:0] n_rec;
    logic [NW-1:0] err_abs;
    logic          err_over;
    logic          match;
    logic          r_ge_d;
    logic          d_zero;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int acc_cyc  = 0;
    int lat;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    divider_reconstruct_seq #(
        .DW (DW)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .n         (n),
        .d         (d),
        .q         (q),
        .r         (r),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_rec     (n_rec),
        .err_abs   (err_abs),
        .err_over  (err_over),
        .match     (match),
        .r_ge_d    (r_ge_d),
        .d_zero    (d_zero)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drives one operand set at a negedge and lets it be accepted on the
    // next posedge. Returns at the negedge after the accept edge.
    task automatic start_txn(input logic [NW-1:0] nn, input logic [DW-1:0] dd,
                             input logic [DW-1:0] qq, input logic [DW-1:0] rr);
        @(negedge clk);
        n = nn; d = dd; q = qq; r = rr;
        in_valid = 1'b1;
        check("in_ready_idle", in_ready, 1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        acc_cyc  = cyc;
    endtask

    // Bounded wait for out_valid. lat is measured in edges since the accept edge.
    task automatic wait_done(input string tag, output int l);
        int guard = 0;
        while (out_valid !== 1'b1 && guard < 40) begin
            @(negedge clk);
            guard++;
        end
        check({tag, ".done_reached"}, out_valid, 1);
        l = cyc - acc_cyc;
    endtask

    task automatic check_res(input string tag, input logic [NW-1:0] e_rec, input logic [NW-1:0] e_err,
                             input logic e_over, input logic e_match, input logic e_rge, input logic e_dz);
        check({tag, ".n_rec"},    n_rec,    e_rec);
        check({tag, ".err_abs"},  err_abs,  e_err);
        check({tag, ".err_over"}, err_over, e_over);
        check({tag, ".match"},    match,    e_match);
        check({tag, ".r_ge_d"},   r_ge_d,   e_rge);
        check({tag, ".d_zero"},   d_zero,   e_dz);
        check({tag, ".in_ready"}, in_ready, 0);
    endtask

    task automatic release_txn(input string tag);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        check({tag, ".rel_out_valid"}, out_valid, 0);
        check({tag, ".rel_in_ready"},  in_ready,  1);
    endtask

    initial begin
        int accepts[$];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        n = '0; d = '0; q = '0; r = '0;

        // Reset state
        #1;
        check("rst.in_ready",  in_ready,  1);
        check("rst.out_valid", out_valid, 0);
        check("rst.n_rec",     n_rec,     0);
        check("rst.err_abs",   err_abs,   0);
        check("rst.flags",     {err_over, match, r_ge_d, d_zero}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Exact result: 142*7 + 6 = 1000
        start_txn(16'd1000, 8'd7, 8'd142, 8'd6);
        wait_done("exact", lat);
        check("exact.latency", lat, 8);
        check_res("exact", 16'd1000, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        release_txn("exact");

        // Approximate result: 10*9 + 12 = 102 against 100. An in_valid
        // pulse with other operands during MUL must be ignored.
        start_txn(16'd100, 8'd9, 8'd10, 8'd12);
        n = 16'd0; d = 8'd1; q = 8'd1; r = 8'd0;
        in_valid = 1'b1;
        check("busy.in_ready", in_ready, 0);
        @(negedge clk);
        in_valid = 1'b0;
        wait_done("approx", lat);
        check("approx.latency", lat, 8);
        check_res("approx", 16'd102, 16'd2, 1'b1, 1'b0, 1'b1, 1'b0);

        // Backpressure: result must hold for 5 cycles with out_ready low
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.out_valid", out_valid, 1);
            check("hold.in_ready",  in_ready,  0);
            check("hold.n_rec",     n_rec,     16'd102);
            check("hold.err_abs",   err_abs,   16'd2);
            check("hold.flags",     {err_over, match, r_ge_d}, 3'b101);
        end
        release_txn("approx");
        check("after_rel.n_rec", n_rec, 16'd102);

        // Maximum width: 255*255 + 255 = 65280, no wrap
        start_txn(16'd65535, 8'd255, 8'd255, 8'd255);
        wait_done("max", lat);
        check_res("max", 16'd65280, 16'd255, 1'b0, 1'b0, 1'b1, 1'b0);
        release_txn("max");

        // Zero divisor: n_rec = r
        start_txn(16'd5, 8'd0, 8'd37, 8'd5);
        wait_done("dzero", lat);
        check_res("dzero", 16'd5, 16'd0, 1'b0, 1'b1, 1'b1, 1'b1);
        release_txn("dzero");

        // Back-to-back with out_ready tied high: one accept every 10 cycles
        @(negedge clk);
        n = 16'd1000; d = 8'd7; q = 8'd142; r = 8'd6;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 45; i++) begin
            if (in_ready === 1'b1) accepts.push_back(cyc + 1);
            if (out_valid === 1'b1) check("b2b.n_rec", n_rec, 16'd1000);
            @(negedge clk);
        end
        in_valid = 1'b0;
        check("b2b.accept_count_ge4", accepts.size() >= 4, 1);
        for (int i = 1; i < accepts.size(); i++) begin
            check("b2b.period", accepts[i] - accepts[i-1], 10);
        end
        repeat (12) @(negedge clk);
        out_ready = 1'b0;
        check("b2b.drained_in_ready", in_ready, 1);

        // Reset during MUL at cnt=3: outputs clear immediately
        start_txn(16'd100, 8'd9, 8'd10, 8'd12);
        repeat (3) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst.out_valid", out_valid, 0);
        check("midrst.in_ready",  in_ready,  1);
        check("midrst.n_rec",     n_rec,     0);
        check("midrst.err_abs",   err_abs,   0);
        check("midrst.flags",     {err_over, match, r_ge_d, d_zero}, 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst.rel_in_ready",  in_ready,  1);
        check("midrst.rel_out_valid", out_valid, 0);

        start_txn(16'd1000, 8'd7, 8'd142, 8'd6);
        wait_done("post_rst", lat);
        check("post_rst.latency", lat, 8);
        check_res("post_rst", 16'd1000, 16'd0, 1'b0, 1'b1, 1'b0, 1'b0);
        release_txn("post_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_divider_reconstruct_seq
